// File: rtl/load_unit_if.sv
// Request/response bundle between the execute stage, the load unit and data memory.
// The load unit connects through the slave modport; the environment uses master.
interface load_unit_if;
  logic        mem_rd_req_in;
  logic [2:0]  func3_in;
  logic [31:0] iadder_in;
  logic [31:0] dmdata_in;
  logic        dm_ack_in;
  logic [31:0] dmaddr_out;
  logic        dmrd_req_out;
  logic [31:0] lu_output;
  logic        lu_valid_out;
  logic        lu_busy_out;
  logic        lu_timeout_out;
  logic        lu_misaligned_out;

  modport slave (
    input  mem_rd_req_in, func3_in, iadder_in, dmdata_in, dm_ack_in,
    output dmaddr_out, dmrd_req_out, lu_output, lu_valid_out,
           lu_busy_out, lu_timeout_out, lu_misaligned_out
  );

  modport master (
    output mem_rd_req_in, func3_in, iadder_in, dmdata_in, dm_ack_in,
    input  dmaddr_out, dmrd_req_out, lu_output, lu_valid_out,
           lu_busy_out, lu_timeout_out, lu_misaligned_out
  );
endinterface

// File: rtl/load_unit.sv
// RV32I load unit: issues one data-memory read, formats the returned lane, aborts on timeout.
// Optional LOAD_MISALIGN_TRAP_EN traps misaligned LH/LHU/LW in IDLE instead of issuing them.
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic       clk_in,
  input logic       rst_n_in,
  load_unit_if.slave lu
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  func3_q;
  logic [7:0]  cnt_q;
  logic [31:0] result_q;
  logic        timeout_q;
  logic        misaligned_req;
  logic        accept;
  logic        timeout_hit;

  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = off[1] ? data[31:16] : data[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return data;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

`ifdef LOAD_MISALIGN_TRAP_EN
  logic misalign_q;

  assign misaligned_req = ((lu.func3_in[1:0] == 2'b01) && lu.iadder_in[0]) ||
                          ((lu.func3_in == 3'b010) && (lu.iadder_in[1:0] != 2'b00));

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) misalign_q <= 1'b0;
    else           misalign_q <= (state_q == IDLE) && lu.mem_rd_req_in && misaligned_req;
  end

  assign lu.lu_misaligned_out = misalign_q;
`else
  assign misaligned_req       = 1'b0;
  assign lu.lu_misaligned_out = 1'b0;
`endif

  assign accept      = (state_q == IDLE) && lu.mem_rd_req_in && !misaligned_req;
  // The final unacknowledged REQ cycle is the one whose increment would reach the limit.
  assign timeout_hit = (state_q == REQ) && !lu.dm_ack_in && (cnt_q == TIMEOUT_LIMIT - 8'd1);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ: begin
        if (lu.dm_ack_in)      state_d = RESP;
        else if (timeout_hit)  state_d = IDLE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lu.dmrd_req_out = (state_q == REQ);
    lu.lu_busy_out  = (state_q == REQ) || (state_q == RESP);
    lu.lu_valid_out = (state_q == RESP);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      addr_q    <= 32'd0;
      func3_q   <= 3'd0;
      cnt_q     <= 8'd0;
      result_q  <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (accept) begin
        addr_q  <= lu.iadder_in;
        func3_q <= lu.func3_in;
        cnt_q   <= 8'd0;
      end
      if (state_q == REQ) begin
        if (lu.dm_ack_in) begin
          result_q <= format_load(func3_q, addr_q[1:0], lu.dmdata_in);
        end else begin
          cnt_q <= cnt_q + 8'd1;
          if (timeout_hit) result_q <= 32'd0;
        end
      end
    end
  end

  assign lu.dmaddr_out     = {addr_q[31:2], 2'b00};
  assign lu.lu_output      = result_q;
  assign lu.lu_timeout_out = timeout_q;

endmodule
